// File: rtl/pcr_file_pkg.sv
// -----------------------------------------------------------------------------
// pcr_file_pkg
// Shared constants and types for the privileged-control-register (PCR) file:
// command encodings, PCR indices, status bit positions, interrupt numbers,
// the status field struct and a helper that packs it into a 32-bit word.
// No ports (package).
// -----------------------------------------------------------------------------
package pcr_file_pkg;

  localparam int PCR_XLEN = 32;

  // PCR command encodings carried on pcr_cmd
  localparam logic [1:0] PCR_CMD_READ  = 2'b00;
  localparam logic [1:0] PCR_CMD_WRITE = 2'b01;
  localparam logic [1:0] PCR_CMD_SET   = 2'b10;
  localparam logic [1:0] PCR_CMD_CLEAR = 2'b11;

  // PCR indices
  localparam logic [4:0] PCR_ADDR_STATUS   = 5'd0;
  localparam logic [4:0] PCR_ADDR_EPC      = 5'd1;
  localparam logic [4:0] PCR_ADDR_BADVADDR = 5'd2;
  localparam logic [4:0] PCR_ADDR_EVEC     = 5'd3;
  localparam logic [4:0] PCR_ADDR_COUNT    = 5'd4;
  localparam logic [4:0] PCR_ADDR_COMPARE  = 5'd5;
  localparam logic [4:0] PCR_ADDR_CAUSE    = 5'd6;
  localparam logic [4:0] PCR_ADDR_K0       = 5'd12;
  localparam logic [4:0] PCR_ADDR_K1       = 5'd13;
  localparam logic [4:0] PCR_ADDR_TOHOST   = 5'd30;
  localparam logic [4:0] PCR_ADDR_FROMHOST = 5'd31;

  // status bit positions and field ranges
  localparam int STATUS_S     = 0;
  localparam int STATUS_PS    = 1;
  localparam int STATUS_EI    = 2;
  localparam int STATUS_PEI   = 3;
  localparam int STATUS_IM_LO = 16;
  localparam int STATUS_IM_HI = 23;
  localparam int STATUS_IP_LO = 24;
  localparam int STATUS_IP_HI = 31;

  // interrupt numbers within IM/IP
  localparam int IRQ_TIMER = 7;
  localparam int IRQ_HOST  = 6;

  // Writable status fields; IP is derived from live sources, not stored.
  typedef struct packed {
    logic [7:0] im;
    logic       pei;
    logic       ei;
    logic       ps;
    logic       s;
  } status_t;

  localparam status_t STATUS_RESET = '{im: 8'h00, pei: 1'b0, ei: 1'b0, ps: 1'b0, s: 1'b1};

  // Build the architectural status word; unused bits read as zero.
  function automatic logic [31:0] pack_status(input status_t st, input logic [7:0] ip);
    logic [31:0] w;
    w = 32'h0000_0000;
    w[STATUS_IP_HI:STATUS_IP_LO] = ip;
    w[STATUS_IM_HI:STATUS_IM_LO] = st.im;
    w[STATUS_PEI]                = st.pei;
    w[STATUS_EI]                 = st.ei;
    w[STATUS_PS]                 = st.ps;
    w[STATUS_S]                  = st.s;
    return w;
  endfunction

endpackage

// File: rtl/pcr_file_if.sv
// -----------------------------------------------------------------------------
// pcr_file_if
// PCR command bus between instruction decode/execute (master) and the PCR
// file (slave).
//   pcr_enable  master->slave  PCR instruction in execute
//   pcr_cmd     master->slave  00 read, 01 write, 10 set, 11 clear
//   pcr_addr    master->slave  PCR index
//   pcr_wdata   master->slave  operand for write/set/clear
//   pcr_rdata   slave->master  old value of the addressed PCR (combinational)
// -----------------------------------------------------------------------------
interface pcr_file_if
  import pcr_file_pkg::*;
#(
  parameter int XLEN = PCR_XLEN
) ();

  logic            pcr_enable;
  logic [1:0]      pcr_cmd;
  logic [4:0]      pcr_addr;
  logic [XLEN-1:0] pcr_wdata;
  logic [XLEN-1:0] pcr_rdata;

  modport master (
    output pcr_enable,
    output pcr_cmd,
    output pcr_addr,
    output pcr_wdata,
    input  pcr_rdata
  );

  modport slave (
    input  pcr_enable,
    input  pcr_cmd,
    input  pcr_addr,
    input  pcr_wdata,
    output pcr_rdata
  );

endinterface

// File: rtl/pcr_file_timer.sv
// -----------------------------------------------------------------------------
// pcr_timer
// Free-running cycle counter with compare register and timer pending bit.
//   clk, reset_n      clock, synchronous active-low reset
//   i_count_ld        load count with i_count_wdata instead of incrementing
//   i_count_wdata     count load value
//   i_compare_ld      load compare with i_compare_wdata, clears pending
//   i_compare_wdata   compare load value
//   o_count           current count
//   o_compare         current compare
//   o_pending         timer interrupt pending (IP[7])
// -----------------------------------------------------------------------------
module pcr_timer
  import pcr_file_pkg::*;
#(
  parameter int              XLEN        = PCR_XLEN,
  parameter logic [XLEN-1:0] COUNT_RESET = '0
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            i_count_ld,
  input  logic [XLEN-1:0] i_count_wdata,
  input  logic            i_compare_ld,
  input  logic [XLEN-1:0] i_compare_wdata,
  output logic [XLEN-1:0] o_count,
  output logic [XLEN-1:0] o_compare,
  output logic            o_pending
);

  logic [XLEN-1:0] r_count;
  logic [XLEN-1:0] r_compare;
  logic            r_pending;
  logic [XLEN-1:0] w_next_count;

  // Next count: a loaded value replaces the increment for that cycle.
  always_comb begin
    w_next_count = r_count + XLEN'(1);
    if (i_count_ld) begin
      w_next_count = i_count_wdata;
    end else begin
      w_next_count = r_count + XLEN'(1);
    end
  end

  // Counter, compare and pending state; a compare write beats a same-cycle match.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_count   <= COUNT_RESET;
      r_compare <= '0;
      r_pending <= 1'b0;
    end else begin
      r_count <= w_next_count;
      if (i_compare_ld) begin
        r_compare <= i_compare_wdata;
        r_pending <= 1'b0;
      end else if (w_next_count == r_compare) begin
        r_pending <= 1'b1;
      end
    end
  end

  assign o_count   = r_count;
  assign o_compare = r_compare;
  assign o_pending = r_pending;

endmodule

// File: rtl/pcr_file.sv
// -----------------------------------------------------------------------------
// pcr_file
// Execute-stage responder for PCR commands. Holds status, epc, badvaddr, evec,
// count, compare, cause, k0, k1, tohost and fromhost; applies read/write/set/
// clear and returns the pre-update value; handles trap entry/return, the timer
// interrupt and the tohost/fromhost host handshake.
//   clk, reset_n          clock, synchronous active-low reset
//   bus (slave)           PCR command bus: enable, cmd, addr, wdata -> rdata
//   stall                 pipeline stalled; only count keeps moving
//   exception, exception_cause/_pc/_badvaddr   trap taken this cycle
//   eret                  return from trap
//   evec, epc             trap vector / return PC
//   supervisor            status.S
//   irq                   EI & |(IM & IP), combinational
//   tohost, tohost_valid  tohost register and its nonzero flag
//   tohost_clear          host consumed tohost
//   fromhost_wr, fromhost_wdata  host write into fromhost
// -----------------------------------------------------------------------------
module pcr_file
  import pcr_file_pkg::*;
#(
  parameter int              XLEN        = PCR_XLEN,
  parameter logic [XLEN-1:0] COUNT_RESET = '0
) (
  input  logic            clk,
  input  logic            reset_n,
  pcr_file_if.slave       bus,
  input  logic            stall,
  input  logic            exception,
  input  logic [4:0]      exception_cause,
  input  logic [XLEN-1:0] exception_pc,
  input  logic [XLEN-1:0] exception_badvaddr,
  input  logic            eret,
  output logic [XLEN-1:0] evec,
  output logic [XLEN-1:0] epc,
  output logic            supervisor,
  output logic            irq,
  output logic [XLEN-1:0] tohost,
  output logic            tohost_valid,
  input  logic            tohost_clear,
  input  logic            fromhost_wr,
  input  logic [XLEN-1:0] fromhost_wdata
);

  status_t         r_status;
  logic [XLEN-1:0] r_epc;
  logic [XLEN-1:0] r_badvaddr;
  logic [XLEN-1:0] r_evec;
  logic [XLEN-1:0] r_cause;
  logic [XLEN-1:0] r_k0;
  logic [XLEN-1:0] r_k1;
  logic [XLEN-1:0] r_tohost;
  logic [XLEN-1:0] r_fromhost;

  logic [XLEN-1:0] w_count;
  logic [XLEN-1:0] w_compare;
  logic            w_timer_pending;
  logic [7:0]      w_ip;
  logic [XLEN-1:0] w_rdata;
  logic [XLEN-1:0] w_new;
  logic            w_wr;
  logic            w_exc;
  logic            w_eret;

  // An exception cancels the PCR write of the same instruction; eret yields to exception.
  assign w_wr   = bus.pcr_enable & ~stall & ~exception & (bus.pcr_cmd != PCR_CMD_READ);
  assign w_exc  = exception & ~stall;
  assign w_eret = eret & ~stall & ~exception;

  assign w_ip = {w_timer_pending, |r_fromhost, 6'b00_0000};

  pcr_timer #(
    .XLEN        (XLEN),
    .COUNT_RESET (COUNT_RESET)
  ) u_timer (
    .clk             (clk),
    .reset_n         (reset_n),
    .i_count_ld      (w_wr && (bus.pcr_addr == PCR_ADDR_COUNT)),
    .i_count_wdata   (w_new),
    .i_compare_ld    (w_wr && (bus.pcr_addr == PCR_ADDR_COMPARE)),
    .i_compare_wdata (w_new),
    .o_count         (w_count),
    .o_compare       (w_compare),
    .o_pending       (w_timer_pending)
  );

  // Read mux: pre-update value of the addressed PCR; unmapped indices read zero.
  always_comb begin
    w_rdata = '0;
    case (bus.pcr_addr)
      PCR_ADDR_STATUS:   w_rdata = XLEN'(pack_status(r_status, w_ip));
      PCR_ADDR_EPC:      w_rdata = r_epc;
      PCR_ADDR_BADVADDR: w_rdata = r_badvaddr;
      PCR_ADDR_EVEC:     w_rdata = r_evec;
      PCR_ADDR_COUNT:    w_rdata = w_count;
      PCR_ADDR_COMPARE:  w_rdata = w_compare;
      PCR_ADDR_CAUSE:    w_rdata = r_cause;
      PCR_ADDR_K0:       w_rdata = r_k0;
      PCR_ADDR_K1:       w_rdata = r_k1;
      PCR_ADDR_TOHOST:   w_rdata = r_tohost;
      PCR_ADDR_FROMHOST: w_rdata = r_fromhost;
      default:           w_rdata = '0;
    endcase
  end

  assign bus.pcr_rdata = w_rdata;

  // New value for the addressed PCR under write/set/clear.
  always_comb begin
    w_new = w_rdata;
    case (bus.pcr_cmd)
      PCR_CMD_WRITE: w_new = bus.pcr_wdata;
      PCR_CMD_SET:   w_new = w_rdata | bus.pcr_wdata;
      PCR_CMD_CLEAR: w_new = w_rdata & ~bus.pcr_wdata;
      default:       w_new = w_rdata;
    endcase
  end

  // Status: trap entry, then trap return, then a core write (IP is never stored).
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_status <= STATUS_RESET;
    end else if (w_exc) begin
      r_status.ps  <= r_status.s;
      r_status.s   <= 1'b1;
      r_status.pei <= r_status.ei;
      r_status.ei  <= 1'b0;
    end else if (w_eret) begin
      r_status.s  <= r_status.ps;
      r_status.ei <= r_status.pei;
    end else if (w_wr && (bus.pcr_addr == PCR_ADDR_STATUS)) begin
      r_status.s   <= w_new[STATUS_S];
      r_status.ps  <= w_new[STATUS_PS];
      r_status.ei  <= w_new[STATUS_EI];
      r_status.pei <= w_new[STATUS_PEI];
      r_status.im  <= w_new[STATUS_IM_HI:STATUS_IM_LO];
    end
  end

  // Trap capture registers; a trap overrides core writes to them.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_epc      <= '0;
      r_badvaddr <= '0;
      r_cause    <= '0;
    end else if (w_exc) begin
      r_epc      <= exception_pc;
      r_badvaddr <= exception_badvaddr;
      r_cause    <= XLEN'(exception_cause);
    end else if (w_wr) begin
      if (bus.pcr_addr == PCR_ADDR_EPC)      r_epc      <= w_new;
      if (bus.pcr_addr == PCR_ADDR_BADVADDR) r_badvaddr <= w_new;
      if (bus.pcr_addr == PCR_ADDR_CAUSE)    r_cause    <= w_new;
    end
  end

  // Plain software registers; evec is kept word aligned.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_evec <= '0;
      r_k0   <= '0;
      r_k1   <= '0;
    end else if (w_wr) begin
      if (bus.pcr_addr == PCR_ADDR_EVEC) r_evec <= {w_new[XLEN-1:2], 2'b00};
      if (bus.pcr_addr == PCR_ADDR_K0)   r_k0   <= w_new;
      if (bus.pcr_addr == PCR_ADDR_K1)   r_k1   <= w_new;
    end
  end

  // tohost: a core write beats the host's clear in the same cycle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_tohost <= '0;
    end else if (w_wr && (bus.pcr_addr == PCR_ADDR_TOHOST)) begin
      r_tohost <= w_new;
    end else if (tohost_clear) begin
      r_tohost <= '0;
    end
  end

  // fromhost: the host side is not pipeline state, so stall does not gate it; host wins.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_fromhost <= '0;
    end else if (fromhost_wr) begin
      r_fromhost <= fromhost_wdata;
    end else if (w_wr && (bus.pcr_addr == PCR_ADDR_FROMHOST)) begin
      r_fromhost <= w_new;
    end
  end

  assign evec         = r_evec;
  assign epc          = r_epc;
  assign supervisor   = r_status.s;
  assign irq          = r_status.ei & (|(r_status.im & w_ip));
  assign tohost       = r_tohost;
  assign tohost_valid = |r_tohost;

endmodule

// File: doc/pcr_file.md
Name: pcr_file

Overview:
- Responder for the privileged-control-register (PCR) commands produced by instruction decode (`pcr_enable`, `pcr_cmd`).
- Holds the 32-bit PCRs: status, epc, badvaddr, evec, count, compare, cause, k0, k1, tohost, fromhost.
- Executes read/write/set/clear commands and returns the old value for the `WB_PCR` writeback path.
- Maintains a free-running cycle counter with compare-match timer interrupt, trap/eret state updates, and a tohost/fromhost host handshake.
- Sits in the execute stage, beside the ALU.

Parameters:
- XLEN, 32, PCR data width.
- COUNT_RESET, 0, reset value of count.

Ports:
- clk  input  1  clock.
- reset_n  input  1  synchronous, active-low reset.
- pcr_enable  input  1  PCR instruction in execute.
- pcr_cmd  input  2  00 read, 01 write, 10 set, 11 clear.
- pcr_addr  input  5  PCR index.
- pcr_wdata  input  XLEN  operand for write/set/clear.
- stall  input  1  pipeline stalled; suppresses all architectural updates except count.
- pcr_rdata  output  XLEN  old value of addressed PCR (combinational).
- exception  input  1  trap taken this cycle.
- exception_cause  input  5  cause code.
- exception_pc  input  XLEN  faulting PC.
- exception_badvaddr  input  XLEN  faulting address.
- eret  input  1  return from trap.
- evec  output  XLEN  trap vector.
- epc  output  XLEN  return PC.
- supervisor  output  1  status.S.
- irq  output  1  interrupt request to the pipeline.
- tohost  output  XLEN  tohost register.
- tohost_valid  output  1  tohost != 0.
- tohost_clear  input  1  host consumed tohost; zero it.
- fromhost_wr  input  1  host write strobe.
- fromhost_wdata  input  XLEN  host data.

Behaviour:
- Addresses: 0 status, 1 epc, 2 badvaddr, 3 evec, 4 count, 5 compare, 6 cause, 12 k0, 13 k1, 30 tohost, 31 fromhost. Unmapped addresses read 0; writes to them are ignored.
- status fields: S[0], PS[1], EI[2], PEI[3], IM[23:16], IP[31:24]. IP is read-only: writes, sets and clears to it are ignored. Remaining bits read 0.
- Reset (`reset_n` low at a clk edge):
  - status = 0x0000_0001 (S=1).
  - count = COUNT_RESET.
  - All other PCRs and timer pending = 0.
  - Outputs follow from these values; `irq` = 0 and `tohost_valid` = 0.
  - Reset overrides every simultaneous event.
- `pcr_rdata` reflects the pre-update value in the same cycle.
- Command effect: wr = `pcr_enable` & ~`stall` & ~`exception` & cmd != 00. On wr, new = wdata (01), old | wdata (10), or old & ~wdata (11), written at the next edge.
- count:
  - Increments every cycle regardless of stall, wrapping 0xFFFF_FFFF -> 0.
  - A PCR write to count loads the new value exactly; no +1 in that cycle.
- Timer:
  - The timer pending bit IP[7] is set at the edge where next count == compare.
  - Any write to compare clears IP[7]; clear takes priority over a same-cycle match.
- `irq` = EI & |(IM & IP), registered-free (combinational from current state).
- exception (priority over eret and over any PCR write):
  - epc <= exception_pc; badvaddr <= exception_badvaddr; cause <= exception_cause zero-extended.
  - PS <= S; S <= 1; PEI <= EI; EI <= 0.
- eret (when no exception): S <= PS; EI <= PEI. An eret coinciding with a PCR write to status applies the eret and drops the write.
- tohost:
  - `tohost_clear` zeroes tohost.
  - A core write in the same cycle wins over `tohost_clear`.
  - Writing a nonzero value while valid overwrites it.
- fromhost:
  - `fromhost_wr` loads fromhost and wins over a same-cycle core write.
  - IP[6] = (fromhost != 0).
- evec[1:0] are forced to 0 on write.

Decomposition:
- consts.vh gains:
  - `PCR_CMD_READ/WRITE/SET/CLEAR`.
  - `PCR_ADDR_*` for every index.
  - `STATUS_S/PS/EI/PEI` bit positions and `STATUS_IM`/`STATUS_IP` ranges.
  - `IRQ_TIMER` = 7 and `IRQ_HOST` = 6.
- One sub-module: `pcr_timer`. It holds count, compare and IP[7], with load ports for count and compare and a pending output.

Test Plan:
- Reset, then read addr 0 and addr 4 on consecutive cycles -> rdata 0x0000_0001, then 1 (count = COUNT_RESET+1 one cycle after reset release).
- Write k0 = 0xDEAD_BEEF, set k0 with 0x0000_0010, clear with 0xDEAD_0000 -> subsequent reads 0xDEAD_BEEF, 0xDEAD_BEFF, 0x0000_BEFF; each command's rdata shows the prior value.
- Set IM[7] and EI; write compare = 100; write count = 95 -> irq rises at the edge where count becomes 100; writing compare = 200 drops irq the next cycle.
- Exception (cause 5, pc 0x400, badvaddr 0x1234) in the same cycle as a write to k1 -> epc = 0x400, cause = 5, S = 1, EI = 0, k1 unchanged; later eret restores S/EI from PS/PEI.
- Write tohost = 1 -> tohost_valid = 1; assert tohost_clear with a simultaneous write of 2 -> tohost = 2; a lone tohost_clear -> tohost_valid = 0.
- fromhost_wr = 7 -> IP[6] = 1 in the status read; a write to status IP bits leaves IP unchanged; stall = 1 during a write -> target unchanged while count still increments.
